// File: rtl/reg_writeback.sv
// Write-back unit: accepts an 8-bit ALU result over valid/ready and writes one
// or two nibbles into the 4-bit register bank, stalling while the bank is busy.
module reg_writeback #(
  parameter int TAMDATA = 4,
  parameter int ADDR_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 res_valid,
  output logic                 res_ready,
  input  logic [2*TAMDATA-1:0] res_data,
  input  logic [1:0]           res_mode,
  input  logic [ADDR_W-1:0]    dst_addr,
  input  logic                 bank_busy,
  output logic                 wr,
  output logic [ADDR_W-1:0]    wr_addr,
  output logic [TAMDATA-1:0]   wr_data,
  output logic                 done,
  output logic [1:0]           dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_W0   = 2'd1;
  localparam logic [1:0] S_W1   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Handshake: a result transfers on a rising edge where res_valid && res_ready;
  // res_ready is high only in IDLE, and the source must hold res_valid until then.

  logic [1:0]           state_q, state_d;
  logic [2*TAMDATA-1:0] data_q;
  logic [1:0]           mode_q;
  logic [ADDR_W-1:0]    addr_q;
  logic                 xfer;
  logic                 hi_first;
  logic [TAMDATA-1:0]   nib_hi, nib_lo, first_nib, second_nib;
  logic [ADDR_W-1:0]    addr_next;

  assign xfer = res_valid && res_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (xfer) state_d = S_W0;
      S_W0:   if (!bank_busy) state_d = mode_q[1] ? S_W1 : S_DONE;
      S_W1:   if (!bank_busy) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      mode_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (xfer) begin
        data_q <= res_data;
        mode_q <= res_mode;
        addr_q <= dst_addr;
      end
    end
  end

  // Modes 01 and 10 lead with the high nibble; 00 and 11 lead with the low one.
  assign hi_first   = (mode_q == 2'b01) || (mode_q == 2'b10);
  assign nib_hi     = data_q[2*TAMDATA-1:TAMDATA];
  assign nib_lo     = data_q[TAMDATA-1:0];
  assign first_nib  = hi_first ? nib_hi : nib_lo;
  assign second_nib = hi_first ? nib_lo : nib_hi;
  assign addr_next  = addr_q + 1'b1;

  always_comb begin
    res_ready = (state_q == S_IDLE);
    done      = (state_q == S_DONE);
    wr        = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    if (state_q == S_W0) begin
      wr      = 1'b1;
      wr_addr = addr_q;
      wr_data = first_nib;
    end else if (state_q == S_W1) begin
      wr      = 1'b1;
      wr_addr = addr_next;
      wr_data = second_nib;
    end
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: per-cycle output checks plus a queue of
// expected completed bank writes filled by the stimulus and drained by a monitor.
module tb_reg_writeback;

  logic       clk;
  logic       rst_n;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [1:0] res_mode;
  logic [1:0] dst_addr;
  logic       bank_busy;
  logic       wr;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;
  logic       done;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_seen = 0;
  int done_exp = 0;
  logic [5:0] exp_q[$];

  reg_writeback #(.TAMDATA(4), .ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_mode(res_mode), .dst_addr(dst_addr),
    .bank_busy(bank_busy),
    .wr(wr), .wr_addr(wr_addr), .wr_data(wr_data),
    .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // scoreboard: a write completes at the next edge when wr && !bank_busy
  always @(negedge clk) begin
    if (rst_n) begin
      if (done) done_seen++;
      if (wr && !bank_busy) begin
        if (exp_q.size() == 0) check("extra_write", 16'({wr_addr, wr_data}), 16'h0);
        else check("write", 16'({wr_addr, wr_data}), 16'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // drivers
  task automatic send(input logic [7:0] d, input logic [1:0] m, input logic [1:0] a);
    int n;
    res_valid = 1'b1;
    res_data  = d;
    res_mode  = m;
    dst_addr  = a;
    n = 0;
    while (!res_ready && n < 20) begin
      tick();
      n++;
    end
    if (!res_ready) check("ready_timeout", 16'(res_ready), 16'h1);
    tick();
    res_valid = 1'b0;
  endtask

  task automatic run_txn(input logic [7:0] d, input logic [1:0] m, input logic [1:0] a,
                         input int nw, input logic [1:0] a0, input logic [3:0] d0,
                         input logic [1:0] a1, input logic [3:0] d1);
    exp_q.push_back({a0, d0});
    if (nw == 2) exp_q.push_back({a1, d1});
    done_exp++;
    send(d, m, a);
    check("w0_wr", 16'(wr), 16'h1);
    check("w0_addr", 16'(wr_addr), 16'(a0));
    check("w0_data", 16'(wr_data), 16'(d0));
    check("w0_ready", 16'(res_ready), 16'h0);
    tick();
    if (nw == 2) begin
      check("w1_wr", 16'(wr), 16'h1);
      check("w1_addr", 16'(wr_addr), 16'(a1));
      check("w1_data", 16'(wr_data), 16'(d1));
      tick();
    end
    check("done_hi", 16'(done), 16'h1);
    check("done_wr", 16'(wr), 16'h0);
    check("done_ready", 16'(res_ready), 16'h0);
    tick();
    check("idle_done", 16'(done), 16'h0);
    check("idle_ready", 16'(res_ready), 16'h1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_ready"}, 16'(res_ready), 16'h1);
    check({tag, "_wr"}, 16'(wr), 16'h0);
    check({tag, "_addr"}, 16'(wr_addr), 16'h0);
    check({tag, "_data"}, 16'(wr_data), 16'h0);
    check({tag, "_done"}, 16'(done), 16'h0);
    check({tag, "_state"}, 16'(dbg_state), 16'h0);
  endtask

  initial begin
    int t0;
    int dsnap;
    rst_n = 1'b0;
    res_valid = 1'b0;
    res_data = '0;
    res_mode = '0;
    dst_addr = '0;
    bank_busy = 1'b0;
    tick();
    tick();
    check_reset_outs("rst");
    rst_n = 1'b1;

    // asynchronous reset while stalled in W0
    bank_busy = 1'b1;
    send(8'h5A, 2'b00, 2'd2);
    check("pre_async_wr", 16'(wr), 16'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outs("async");
    tick();
    rst_n = 1'b1;
    bank_busy = 1'b0;

    // single and double writes, address wrap
    run_txn(8'hA5, 2'b00, 2'd1, 1, 2'd1, 4'h5, 2'd0, 4'h0);
    run_txn(8'h3C, 2'b10, 2'd2, 2, 2'd2, 4'h3, 2'd3, 4'hC);
    run_txn(8'h3C, 2'b11, 2'd2, 2, 2'd2, 4'hC, 2'd3, 4'h3);
    run_txn(8'h7E, 2'b10, 2'd3, 2, 2'd3, 4'h7, 2'd0, 4'hE);
    run_txn(8'hA5, 2'b01, 2'd0, 1, 2'd0, 4'hA, 2'd0, 4'h0);

    // stalls: 3 busy cycles in W0, 2 in W1
    exp_q.push_back({2'd1, 4'h6});
    exp_q.push_back({2'd2, 4'h9});
    done_exp++;
    bank_busy = 1'b1;
    send(8'h96, 2'b11, 2'd1);
    t0 = cyc;
    for (int i = 0; i < 4; i++) begin
      bank_busy = (i < 3);
      check("st0_wr", 16'(wr), 16'h1);
      check("st0_ad", 16'({wr_addr, wr_data}), 16'h16);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      bank_busy = (i < 2);
      check("st1_wr", 16'(wr), 16'h1);
      check("st1_ad", 16'({wr_addr, wr_data}), 16'h29);
      tick();
    end
    bank_busy = 1'b0;
    check("st_done", 16'(done), 16'h1);
    check("st_lat", 16'(cyc - t0), 16'd7);
    tick();

    // input isolation with res_valid held high
    exp_q.push_back({2'd2, 4'h3});
    exp_q.push_back({2'd3, 4'hC});
    exp_q.push_back({2'd3, 4'h2});
    done_exp += 2;
    send(8'h3C, 2'b10, 2'd2);
    res_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      res_data = 8'($urandom_range(0, 255));
      res_mode = 2'($urandom_range(0, 3));
      dst_addr = 2'($urandom_range(0, 3));
      check("iso_ready", 16'(res_ready), 16'h0);
      tick();
    end
    res_data = 8'h21;
    res_mode = 2'b01;
    dst_addr = 2'd3;
    check("iso_done", 16'(done), 16'h1);
    check("iso_ready_d", 16'(res_ready), 16'h0);
    tick();
    check("iso_idle_ready", 16'(res_ready), 16'h1);
    tick();
    res_valid = 1'b0;
    check("iso2_ad", 16'({wr_addr, wr_data}), 16'h32);
    tick();
    check("iso2_done", 16'(done), 16'h1);
    tick();

    // reset while stalled in W1
    exp_q.push_back({2'd1, 4'h3});
    send(8'h3C, 2'b10, 2'd1);
    tick();
    bank_busy = 1'b1;
    check("pre_rst_w1", 16'(dbg_state), 16'h2);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_w1_wr", 16'(wr), 16'h0);
    check("rst_w1_done", 16'(done), 16'h0);
    dsnap = done_seen;
    tick();
    rst_n = 1'b1;
    bank_busy = 1'b0;
    tick();
    check("rst_w1_nodone", 16'(done_seen), 16'(dsnap));
    run_txn(8'hF0, 2'b01, 2'd0, 1, 2'd0, 4'hF, 2'd0, 4'h0);

    tick();
    check("pending_writes", 16'(exp_q.size()), 16'h0);
    check("done_count", 16'(done_seen), 16'(done_exp));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    check("global_timeout", 16'h0, 16'h1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
